// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter with built-in oversampling baud-tick generator.
// Accepts a byte on i_tx_start, shifts it out LSB first, pulses o_tx_done at frame end.
`timescale 1ns/1ps
module uart_tx_frame #(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int DIV  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] OS_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SB_LAST   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NB_LAST   = NW'(NB_DATA - 1);

    generate
        if (DIV < 1) begin : g_cfg_err
            $error("uart_tx_frame: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state, w_state_nx;
    logic [TW-1:0]        r_tick_cnt, w_tick_nx;
    logic [SW-1:0]        r_s_cnt, w_s_nx;
    logic [NW-1:0]        r_n_cnt, w_n_nx;
    logic [NB_DATA-1:0]   r_shreg, w_sh_nx;
    logic                 r_tx, w_tx_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_done, w_done_nx;
    logic                 w_tick;

    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_s_cnt    <= '0;
            r_n_cnt    <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tick_cnt <= w_tick_nx;
            r_s_cnt    <= w_s_nx;
            r_n_cnt    <= w_n_nx;
            r_shreg    <= w_sh_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = w_tick ? '0 : r_tick_cnt + 1'b1;
        w_s_nx     = r_s_cnt;
        w_n_nx     = r_n_cnt;
        w_sh_nx    = r_shreg;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                // Restart the baud divider on acceptance so frame timing is exact.
                if (i_tx_start) begin
                    w_state_nx = START;
                    w_sh_nx    = i_tx_data;
                    w_tick_nx  = '0;
                    w_s_nx     = '0;
                    w_n_nx     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s_cnt == OS_LAST) begin
                        w_state_nx = DATA;
                        w_s_nx     = '0;
                        w_n_nx     = '0;
                    end else begin
                        w_s_nx = r_s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == OS_LAST) begin
                        w_s_nx  = '0;
                        w_sh_nx = r_shreg >> 1;
                        if (r_n_cnt == NB_LAST) w_state_nx = STOP;
                        else                    w_n_nx     = r_n_cnt + 1'b1;
                    end else begin
                        w_s_nx = r_s_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == SB_LAST) begin
                        w_state_nx = IDLE;
                        w_s_nx     = '0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_s_nx = r_s_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
        // Outputs are registered from the next-state view so they change on the same edge as the state.
        w_busy_nx = (w_state_nx != IDLE);
        case (w_state_nx)
            START:   w_tx_nx = 1'b0;
            DATA:    w_tx_nx = w_sh_nx[0];
            default: w_tx_nx = 1'b1;
        endcase
    end

endmodule
